// File: rtl/adc_to_bcd.sv
// ============================================================================
// Module      : adc_to_bcd
// Description : Scales a 10-bit ADC sample to millivolts and converts it to
//               four BCD digits with a sequential double-dabble engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_to_bcd #(
    parameter int VREF_MV = 3300
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [9:0] data_in,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_SCALE   = 2'd1;
    localparam logic [1:0]  ST_CONVERT = 2'd2;
    localparam logic [1:0]  ST_DONE    = 2'd3;
    localparam logic [21:0] C_VREF     = 22'(VREF_MV);
    localparam logic [3:0]  C_LAST_BIT = 4'd11;

    logic [1:0]  state_q, state_d;
    logic [9:0]  sample_q, sample_d;
    logic [27:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] bcd_q, bcd_d;
    logic [21:0] w_product;
    logic [27:0] w_adjusted;

    // State register
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (data_valid) state_d = ST_SCALE;
            ST_SCALE:   state_d = ST_CONVERT;
            ST_CONVERT: if (cnt_q == C_LAST_BIT) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == ST_SCALE) || (state_q == ST_CONVERT);
        done = (state_q == ST_DONE);
    end

    // Product never exceeds 22 bits since VREF_MV <= 4096 and the sample < 1024.
    always_comb begin
        w_product = {12'd0, sample_q} * C_VREF;
    end

    // Shift register layout: [27:12] BCD digits, [11:0] binary millivolts.
    always_comb begin
        w_adjusted = shift_q;
        for (int i = 0; i < 4; i++) begin
            if (shift_q[12 + 4*i +: 4] >= 4'd5) begin
                w_adjusted[12 + 4*i +: 4] = shift_q[12 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        sample_d = sample_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (data_valid) sample_d = data_in;
            end
            ST_SCALE: begin
                shift_d = {16'd0, 12'(w_product >> 10)};
                cnt_d   = 4'd0;
            end
            ST_CONVERT: begin
                shift_d = w_adjusted << 1;
                if (cnt_q == C_LAST_BIT) begin
                    cnt_d = 4'd0;
                    bcd_d = shift_d[27:12];
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sample_q <= 10'd0;
            shift_q  <= 28'd0;
            cnt_q    <= 4'd0;
            bcd_q    <= 16'd0;
        end else begin
            sample_q <= sample_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
        end
    end

    assign bcd0 = bcd_q[3:0];
    assign bcd1 = bcd_q[7:4];
    assign bcd2 = bcd_q[11:8];
    assign bcd3 = bcd_q[15:12];

endmodule

`default_nettype wire

// File: doc/adc_to_bcd.md
ADC_TO_BCD -- requirements
Module: adc_to_bcd

Interface
REQ-001 Parameter VREF_MV, default 3300, ADC full-scale reference in millivolts; legal range 1..4096.
REQ-002 sysclk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_valid  input  1  one-cycle strobe from the SPI ADC interface marking a new sample on data_in.
REQ-005 data_in  input  10  raw unsigned ADC sample, valid when data_valid=1.
REQ-006 bcd0  output  4  millivolt units digit, 0..9.
REQ-007 bcd1  output  4  millivolt tens digit, 0..9.
REQ-008 bcd2  output  4  millivolt hundreds digit, 0..9.
REQ-009 bcd3  output  4  millivolt thousands digit, 0..9.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 done  output  1  one-cycle pulse when bcd0..bcd3 take a new result.

Function
REQ-012 The FSM SHALL have states IDLE, SCALE, CONVERT and DONE.
REQ-013 In IDLE, data_valid=1 at edge N SHALL capture data_in and move to SCALE; busy SHALL be high from cycle N+1.
REQ-014 SCALE SHALL last 1 cycle: register mv = (data_in * VREF_MV) >> 10, with a 22-bit product truncated to 12 bits (floor, no rounding).
REQ-015 CONVERT SHALL run shift-add-3 (double dabble) on mv, one bit per cycle, MSB first, for exactly 12 cycles (N+2..N+13).
REQ-016 Each CONVERT iteration SHALL add 3 to any 4-bit BCD digit >= 5 before the left shift.
REQ-017 A 4-bit iteration counter SHALL count 0..11; CONVERT SHALL exit to DONE when the counter reaches 11.
REQ-018 In DONE (cycle N+14), bcd0..bcd3 SHALL load the result, done SHALL be 1 for that single cycle, busy SHALL be 0, and the next state SHALL be IDLE.
REQ-019 Latency from the data_valid edge to the done pulse SHALL be exactly 14 cycles; max throughput SHALL be one sample per 15 cycles.
REQ-020 data_valid asserted while in SCALE, CONVERT or DONE SHALL be ignored, with no queueing and no corruption of the in-flight conversion.
REQ-021 data_valid asserted in the first IDLE cycle after DONE SHALL start a new conversion normally.
REQ-022 bcd0..bcd3 SHALL hold the last result between conversions and SHALL never show intermediate shift-register contents.
REQ-023 With VREF_MV=3300, data_in=1023 SHALL yield 3296; the output SHALL never exceed 4095 for any legal VREF_MV.
REQ-024 data_valid held high continuously SHALL start one conversion per 15 cycles, i.e. a new start each time the FSM returns to IDLE.

Reset
REQ-025 Reset asserted SHALL immediately force IDLE, set busy=0, done=0 and bcd0..bcd3=0, and clear the shift register and counter, without waiting for a clock edge.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; bcd0..bcd3 SHALL read 0.
REQ-027 After reset deasserts, the first data_valid SHALL be accepted on the next rising edge.

Verification
REQ-028 data_in=512, VREF_MV=3300, one data_valid pulse -> done exactly 14 cycles later; bcd3..bcd0=1,6,5,0.
REQ-029 data_in=1023 -> 3,2,9,6; data_in=1 -> 0,0,0,3; data_in=0 -> 0,0,0,0; each with a single done pulse.
REQ-030 data_in=512 pulse, then data_in=0 pulse 5 cycles later -> second pulse ignored; result 1650; busy high for 13 cycles.
REQ-031 data_valid tied high, data_in=700 -> done every 15 cycles; bcd3..bcd0=2,2,5,5 (700*3300>>10=2255).
REQ-032 Reset pulsed at cycle N+7 of a conversion -> no done pulse, all digits 0, busy 0; the next data_valid converts correctly.
REQ-033 Sweep data_in 0..1023 -> every digit <= 9 and the decimal value matches floor(data_in*3300/1024) for all 1024 codes.
